// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/forwarding controller: FSM encoding,
// control-word bit positions driven by the forwarding selects, and shadow-record widths.
package pipeline_ctrl_pkg;

  localparam int REG_IDX_W        = 5;
  localparam int DRAIN_CYCLES_DEF = 3;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } ctrlState_e;

  // Bit positions of the forwarding selects inside the decoder control words
  localparam int ID_CTRL_EXMEM_A  = 1;
  localparam int ID_CTRL_EXMEM_B  = 2;
  localparam int EX_CTRL_EXMEM_A  = 3;
  localparam int EX_CTRL_EXMEM_B  = 4;
  localparam int EX_CTRL_MEMWB_A  = 5;
  localparam int EX_CTRL_MEMWB_B  = 6;
  localparam int MEM_CTRL_MEMWB   = 4;

  // Shadow record: rW plus regWr, fpRegWr, memRd flags
  localparam int SHADOW_FLAG_W    = 3;
  localparam int SHADOW_W         = REG_IDX_W + SHADOW_FLAG_W;

endpackage

// File: rtl/pipeline_hazard_ctrl_match.sv
// Single stage-versus-source comparator: does this pipeline stage write the register
// the ID instruction reads, in the same register class?
module hazard_match #(
  parameter int REG_W = 5
) (
  input  logic             stageRegWr,
  input  logic             stageFpRegWr,
  input  logic [REG_W-1:0] stageRW,
  input  logic [REG_W-1:0] src,
  input  logic             fpSrc,
  output logic             hit
);

  logic classWr;

  assign classWr = fpSrc ? stageFpRegWr : stageRegWr;
  // Integer r0 is hard-wired zero and never a real producer; fp f0 is an ordinary register
  assign hit = classWr && (stageRW == src) && (fpSrc || (src != {REG_W{1'b0}}));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/forwarding controller: tracks EX/MEM destination shadows, picks forwarding
// selects, raises load-use and branch stalls, and drains the pipe before endProgram.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int REG_W        = REG_IDX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] rS1,
  input  logic [REG_W-1:0] rS2,
  input  logic             useS1,
  input  logic             useS2,
  input  logic             fpSrcId,
  input  logic             isStoreId,
  input  logic             isBranchId,
  input  logic [REG_W-1:0] rWId,
  input  logic             regWrId,
  input  logic             fp_regWrId,
  input  logic             memRdId,
  input  logic             haltId,
  output logic [1:0]       fwdIdCtrl,
  output logic [3:0]       fwdExCtrl,
  output logic             memWbMem,
  output logic             stall,
  output logic             ifIdWrIn,
  output logic             pcWr,
  output logic             bubble,
  output logic             endProgram
);

  localparam int             CNT_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(1'b0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  // WB needs no record: the register file writes on the falling edge, so a WB
  // producer is already visible to the ID read.
  logic [REG_W-1:0] exRW, memRW;
  logic             exRegWr, exFpRegWr, exMemRd;
  logic             memRegWr, memFpRegWr, memMemRd;

  ctrlState_e       state, nextState;
  logic [CNT_W-1:0] drainCnt, nextCnt;

  logic exHitA, exHitB, memHitA, memHitB;
  logic exMemExA, exMemExB, memWbExA, memWbExB;
  logic exMemIdA, exMemIdB, storeDataFwd;
  logic loadUse, branchStall, hazard;

  hazard_match #(.REG_W(REG_W)) uExA (
    .stageRegWr(exRegWr), .stageFpRegWr(exFpRegWr), .stageRW(exRW),
    .src(rS1), .fpSrc(fpSrcId), .hit(exHitA)
  );
  hazard_match #(.REG_W(REG_W)) uExB (
    .stageRegWr(exRegWr), .stageFpRegWr(exFpRegWr), .stageRW(exRW),
    .src(rS2), .fpSrc(fpSrcId), .hit(exHitB)
  );
  hazard_match #(.REG_W(REG_W)) uMemA (
    .stageRegWr(memRegWr), .stageFpRegWr(memFpRegWr), .stageRW(memRW),
    .src(rS1), .fpSrc(fpSrcId), .hit(memHitA)
  );
  hazard_match #(.REG_W(REG_W)) uMemB (
    .stageRegWr(memRegWr), .stageFpRegWr(memFpRegWr), .stageRW(memRW),
    .src(rS2), .fpSrc(fpSrcId), .hit(memHitB)
  );

  // Youngest producer wins; a load still in EX cannot forward and is handled as a stall
  assign exMemExA     = exHitA && !exMemRd;
  assign exMemExB     = exHitB && !exMemRd;
  assign memWbExA     = memHitA && !exMemExA;
  assign memWbExB     = memHitB && !exMemExB;
  assign exMemIdA     = isBranchId && memHitA && !memMemRd;
  assign exMemIdB     = isBranchId && useS2 && memHitB && !memMemRd;
  assign storeDataFwd = isStoreId && exHitB && exMemRd;

  assign loadUse      = (useS1 && exHitA && exMemRd) ||
                        (useS2 && exHitB && exMemRd && !isStoreId);
  assign branchStall  = isBranchId && (exHitA || (memHitA && memMemRd));
  assign hazard       = loadUse || branchStall;

  assign fwdIdCtrl    = {exMemIdB, exMemIdA};
  assign fwdExCtrl    = {memWbExB, memWbExA, exMemExB, exMemExA};
  assign memWbMem     = storeDataFwd;

  // Shadow pipeline of destination info; a bubble enters EX as an empty record
  always_ff @(posedge clk) begin
    if (!reset) begin
      exRW       <= {REG_W{1'b0}};
      exRegWr    <= 1'b0;
      exFpRegWr  <= 1'b0;
      exMemRd    <= 1'b0;
      memRW      <= {REG_W{1'b0}};
      memRegWr   <= 1'b0;
      memFpRegWr <= 1'b0;
      memMemRd   <= 1'b0;
    end else begin
      exRW       <= bubble ? {REG_W{1'b0}} : rWId;
      exRegWr    <= bubble ? 1'b0 : regWrId;
      exFpRegWr  <= bubble ? 1'b0 : fp_regWrId;
      exMemRd    <= bubble ? 1'b0 : memRdId;
      memRW      <= exRW;
      memRegWr   <= exRegWr;
      memFpRegWr <= exFpRegWr;
      memMemRd   <= exMemRd;
    end
  end

  // FSM state and drain counter registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= RUN;
      drainCnt <= CNT_ZERO;
    end else begin
      state    <= nextState;
      drainCnt <= nextCnt;
    end
  end

  // Next-state and stall/fetch/bubble/endProgram decode
  always_comb begin
    nextState  = state;
    nextCnt    = drainCnt;
    stall      = 1'b0;
    bubble     = 1'b0;
    ifIdWrIn   = 1'b1;
    pcWr       = 1'b1;
    endProgram = 1'b0;
    case (state)
      RUN: begin
        if (hazard) begin
          stall    = 1'b1;
          bubble   = 1'b1;
          ifIdWrIn = 1'b0;
          pcWr     = 1'b0;
        end else if (haltId) begin
          // halt itself travels down as a bubble; fetch freezes from the next cycle
          bubble    = 1'b1;
          nextState = DRAIN;
          nextCnt   = CNT_LOAD;
        end else begin
          nextState = RUN;
        end
      end
      DRAIN: begin
        bubble   = 1'b1;
        ifIdWrIn = 1'b0;
        pcWr     = 1'b0;
        if (drainCnt == CNT_ZERO) begin
          nextState = HALTED;
        end else begin
          nextCnt = drainCnt - CNT_ONE;
        end
      end
      HALTED: begin
        bubble     = 1'b1;
        ifIdWrIn   = 1'b0;
        pcWr       = 1'b0;
        endProgram = 1'b1;
      end
      default: begin
        nextState = RUN;
        nextCnt   = CNT_ZERO;
      end
    endcase
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: each ID cycle pushes its hand-derived
// expected control outputs; a negedge monitor pops and compares.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rS1, rS2, rWId;
  logic       useS1, useS2, fpSrcId, isStoreId, isBranchId;
  logic       regWrId, fp_regWrId, memRdId, haltId;
  logic [1:0] fwdIdCtrl;
  logic [3:0] fwdExCtrl;
  logic       memWbMem, stall, ifIdWrIn, pcWr, bubble, endProgram;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.DRAIN_CYCLES(3), .REG_W(5)) dut (
    .clk(clk), .reset(reset),
    .rS1(rS1), .rS2(rS2), .useS1(useS1), .useS2(useS2),
    .fpSrcId(fpSrcId), .isStoreId(isStoreId), .isBranchId(isBranchId),
    .rWId(rWId), .regWrId(regWrId), .fp_regWrId(fp_regWrId),
    .memRdId(memRdId), .haltId(haltId),
    .fwdIdCtrl(fwdIdCtrl), .fwdExCtrl(fwdExCtrl), .memWbMem(memWbMem),
    .stall(stall), .ifIdWrIn(ifIdWrIn), .pcWr(pcWr), .bubble(bubble),
    .endProgram(endProgram)
  );

  // low five bits: {stall, ifIdWrIn, pcWr, bubble, endProgram}
  localparam logic [4:0] RUN_O   = 5'b01100;
  localparam logic [4:0] STALL_O = 5'b10010;
  localparam logic [4:0] HALT_O  = 5'b01110;
  localparam logic [4:0] DRAIN_O = 5'b00010;
  localparam logic [4:0] DONE_O  = 5'b00011;

  typedef struct {
    string      name;
    logic [11:0] v;
  } exp_t;

  exp_t        expQ[$];
  exp_t        monE;
  logic [11:0] got;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [11:0] ev(input logic [1:0] fid, input logic [3:0] fex,
                                     input logic mm, input logic [4:0] ctl);
    return {fid, fex, mm, ctl};
  endfunction

  task automatic issue(input string name, input logic [4:0] s1, input logic [4:0] s2,
                       input logic u1, input logic u2, input logic fp, input logic st,
                       input logic br, input logic [4:0] rw, input logic iw,
                       input logic fw, input logic ld, input logic hlt,
                       input logic [11:0] expv);
    exp_t e;
    rS1 = s1; rS2 = s2; useS1 = u1; useS2 = u2; fpSrcId = fp;
    isStoreId = st; isBranchId = br; rWId = rw; regWrId = iw;
    fp_regWrId = fw; memRdId = ld; haltId = hlt;
    e.name = name;
    e.v    = expv;
    expQ.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic intOp(input string name, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [4:0] rw, input logic [11:0] expv);
    issue(name, s1, s2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, rw, 1'b1, 1'b0, 1'b0, 1'b0, expv);
  endtask

  task automatic fpOp(input string name, input logic [4:0] s1, input logic [4:0] s2,
                      input logic [4:0] rw, input logic [11:0] expv);
    issue(name, s1, s2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, rw, 1'b0, 1'b1, 1'b0, 1'b0, expv);
  endtask

  task automatic loadOp(input string name, input logic [4:0] base, input logic [4:0] rw,
                        input logic [11:0] expv);
    issue(name, base, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, rw, 1'b1, 1'b0, 1'b1, 1'b0, expv);
  endtask

  task automatic nopOp(input string name, input logic [11:0] expv);
    issue(name, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, expv);
  endtask

  task automatic haltOp(input string name, input logic [11:0] expv);
    issue(name, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, expv);
  endtask

  // Monitor: compare every presented cycle against the oldest expectation
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      monE = expQ.pop_front();
      got  = {fwdIdCtrl, fwdExCtrl, memWbMem, stall, ifIdWrIn, pcWr, bubble, endProgram};
      checks = checks + 1;
      if (got !== monE.v) begin
        errors = errors + 1;
        $display("FAIL %s: got fwdId/fwdEx/memWbMem/stall/ifId/pc/bubble/end=%b required %b",
                 monE.name, got, monE.v);
      end
    end
  end

  logic [11:0] n0;

  initial begin
    n0 = ev(2'b00, 4'b0000, 1'b0, RUN_O);
    reset = 1'b0;
    rS1 = 5'd0; rS2 = 5'd0; rWId = 5'd0; useS1 = 1'b0; useS2 = 1'b0;
    fpSrcId = 1'b0; isStoreId = 1'b0; isBranchId = 1'b0; regWrId = 1'b0;
    fp_regWrId = 1'b0; memRdId = 1'b0; haltId = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nopOp("reset state", n0);
    reset = 1'b1;

    // EX->EX and MEM->EX forwarding, youngest producer priority
    intOp("add r3", 5'd1, 5'd2, 5'd3, n0);
    intOp("add r4=r3+r1 exMemExA", 5'd3, 5'd1, 5'd4, ev(2'b00, 4'b0001, 1'b0, RUN_O));
    intOp("add r3 b", 5'd1, 5'd2, 5'd3, n0);
    nopOp("nop", n0);
    intOp("sub r5=r1-r3 memWbExB", 5'd1, 5'd3, 5'd5, ev(2'b00, 4'b1000, 1'b0, RUN_O));
    intOp("add r3 c", 5'd1, 5'd2, 5'd3, n0);
    intOp("add r3 d", 5'd1, 5'd2, 5'd3, n0);
    intOp("sub r5 two producers", 5'd1, 5'd3, 5'd5, ev(2'b00, 4'b0010, 1'b0, RUN_O));

    // load-use stall then MEM forwarding on both operands
    loadOp("lw r2", 5'd7, 5'd2, n0);
    intOp("add r6 load-use stall", 5'd2, 5'd2, 5'd6, ev(2'b00, 4'b0000, 1'b0, STALL_O));
    intOp("add r6 after stall", 5'd2, 5'd2, 5'd6, ev(2'b00, 4'b1100, 1'b0, RUN_O));

    // load -> store data without stall
    loadOp("lw r2 b", 5'd7, 5'd2, n0);
    issue("sw r2 store-data fwd", 5'd7, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0,
          1'b0, 1'b0, 1'b0, 1'b0, ev(2'b00, 4'b0000, 1'b1, RUN_O));

    // branch in ID on a producer in EX: stall, then forward from MEM
    intOp("add r8", 5'd1, 5'd9, 5'd8, n0);
    issue("beqz r8 stall", 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0,
          1'b0, 1'b0, 1'b0, 1'b0, ev(2'b00, 4'b0001, 1'b0, STALL_O));
    issue("beqz r8 exMemIdA", 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0,
          1'b0, 1'b0, 1'b0, 1'b0, ev(2'b01, 4'b0100, 1'b0, RUN_O));

    // r0 never forwards or stalls; fp registers (including f0) do
    loadOp("lw r0", 5'd7, 5'd0, n0);
    intOp("add r10=r0+r0", 5'd0, 5'd0, 5'd10, n0);
    fpOp("fmul f2", 5'd4, 5'd5, 5'd2, n0);
    fpOp("fadd f6=f2+f0", 5'd2, 5'd0, 5'd6, ev(2'b00, 4'b0001, 1'b0, RUN_O));
    fpOp("fmul f0", 5'd4, 5'd5, 5'd0, n0);
    fpOp("fadd f8=f6+f0", 5'd6, 5'd0, 5'd8, ev(2'b00, 4'b0110, 1'b0, RUN_O));
    intOp("add r11 int vs fp producers", 5'd6, 5'd8, 5'd11, n0);

    // halt: drain three cycles, endProgram on the fourth
    haltOp("halt", ev(2'b00, 4'b0000, 1'b0, HALT_O));
    nopOp("drain 1", ev(2'b00, 4'b0000, 1'b0, DRAIN_O));
    nopOp("drain 2", ev(2'b00, 4'b0000, 1'b0, DRAIN_O));
    nopOp("drain 3", ev(2'b00, 4'b0000, 1'b0, DRAIN_O));
    nopOp("endProgram", ev(2'b00, 4'b0000, 1'b0, DONE_O));
    haltOp("halted hold", ev(2'b00, 4'b0000, 1'b0, DONE_O));
    reset = 1'b0;
    nopOp("halted at reset assert", ev(2'b00, 4'b0000, 1'b0, DONE_O));
    nopOp("reset from halted", n0);
    reset = 1'b1;

    // reset in the middle of a drain returns to RUN
    haltOp("halt b", ev(2'b00, 4'b0000, 1'b0, HALT_O));
    nopOp("drain b1", ev(2'b00, 4'b0000, 1'b0, DRAIN_O));
    reset = 1'b0;
    nopOp("drain b2 at reset assert", ev(2'b00, 4'b0000, 1'b0, DRAIN_O));
    nopOp("after mid-drain reset", n0);
    reset = 1'b1;
    nopOp("run resumed", n0);
    intOp("add r3 post-reset", 5'd1, 5'd2, 5'd3, n0);
    intOp("add r4 post-reset fwd", 5'd3, 5'd1, 5'd4, ev(2'b00, 4'b0001, 1'b0, RUN_O));
    nopOp("no late endProgram", n0);

    // reset during a load-use stall leaves no residual stall
    loadOp("lw r2 c", 5'd7, 5'd2, n0);
    reset = 1'b0;
    intOp("add r6 stall at reset", 5'd2, 5'd2, 5'd6, ev(2'b00, 4'b0000, 1'b0, STALL_O));
    intOp("add r6 during reset", 5'd2, 5'd2, 5'd6, n0);
    reset = 1'b1;
    intOp("add r6 after reset", 5'd2, 5'd2, 5'd6, n0);

    repeat (4) begin
      if (expQ.size() == 0) break;
      @(negedge clk);
      #1;
    end
    if (expQ.size() != 0) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL scoreboard drain: %0d expectations left, required 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
